// File: rtl/sysid_checker.sv
// sysid_checker: reads sysid word 0 (system ID) and word 1 (timestamp) over Avalon-MM and checks both
// Ports: clock, reset_n (async, active-low); start requests a check (sampled in IDLE);
//   sysid_address/sysid_read/sysid_readdata form the read-only master on the sysid slave;
//   busy/done/pass/id_ok/ts_ok/id_value/ts_value/check_count/fail_count report the last completed check.
module sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1553134226,
  parameter int unsigned READ_LATENCY       = 0,
  parameter bit          AUTO_START         = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        sysid_address,
  output logic        sysid_read,
  input  logic [31:0] sysid_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_ok,
  output logic        ts_ok,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [7:0]  check_count,
  output logic [7:0]  fail_count
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ID   = 3'd1;
  localparam logic [2:0] WAIT_ID = 3'd2;
  localparam logic [2:0] RD_TS   = 3'd3;
  localparam logic [2:0] WAIT_TS = 3'd4;
  localparam logic [2:0] LAT     = 3'(READ_LATENCY);
  logic [2:0] state_q, state_d, cnt_q, cnt_d;
  logic auto_q, done_q, pass_q, id_ok_q, ts_ok_q;
  logic [31:0] id_value_q, ts_value_q;
  logic [7:0] check_count_q, fail_count_q;
  logic launch, rd, waiting, cap_id, cap_ts, id_match, ts_match;
  always_comb begin
    launch   = state_q == IDLE && (start || auto_q);
    rd       = state_q == RD_ID || state_q == RD_TS;
    waiting  = state_q == WAIT_ID || state_q == WAIT_TS;
    // zero latency samples in the strobe cycle; otherwise on the wait cycle where the counter reaches 1
    cap_id   = LAT == 3'd0 ? state_q == RD_ID : state_q == WAIT_ID && cnt_q == 3'd1;
    cap_ts   = LAT == 3'd0 ? state_q == RD_TS : state_q == WAIT_TS && cnt_q == 3'd1;
    id_match = id_value_q == EXPECTED_ID;
    ts_match = sysid_readdata == EXPECTED_TIMESTAMP;
    state_d  = launch ? RD_ID :
               cap_id ? RD_TS :
               cap_ts ? IDLE :
               state_q == RD_ID ? WAIT_ID :
               state_q == RD_TS ? WAIT_TS : state_q;
    cnt_d    = rd ? LAT : cnt_q - 3'(waiting);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      auto_q        <= AUTO_START;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      ts_ok_q       <= 1'b0;
      id_value_q    <= '0;
      ts_value_q    <= '0;
      check_count_q <= '0;
      fail_count_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= cap_ts;
      if (launch) begin
        auto_q  <= 1'b0;
        pass_q  <= 1'b0;
        id_ok_q <= 1'b0;
        ts_ok_q <= 1'b0;
      end
      if (cap_id) id_value_q <= sysid_readdata;
      if (cap_ts) begin
        ts_value_q    <= sysid_readdata;
        ts_ok_q       <= ts_match;
        id_ok_q       <= id_match;
        pass_q        <= id_match && ts_match;
        check_count_q <= check_count_q + 8'd1;
        if (!(id_match && ts_match) && fail_count_q != 8'hFF) fail_count_q <= fail_count_q + 8'd1;
      end
    end
  assign sysid_address = state_q == RD_TS || state_q == WAIT_TS;
  assign sysid_read    = rd;
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign pass          = pass_q;
  assign id_ok         = id_ok_q;
  assign ts_ok         = ts_ok_q;
  assign id_value      = id_value_q;
  assign ts_value      = ts_value_q;
  assign check_count   = check_count_q;
  assign fail_count    = fail_count_q;
endmodule

// File: tb/tb_sysid_checker.sv
// tb_sysid_checker: scoreboard bench for sysid_checker with three latency/auto-start configurations
module tb_sysid_checker;
  localparam logic [31:0] TS = 32'd1553134226;
  localparam logic [31:0] W0 [3] = '{32'd0, 32'd1, 32'h1234_5678};
  logic clock = 1'b0;
  logic [2:0] rst_n, start;
  logic addr [3], rd [3], busy [3], done [3], pass [3], id_ok [3], ts_ok [3];
  logic [31:0] rdata [3], id_val [3], ts_val [3];
  logic [7:0] cc [3], fc [3];
  int cyc = 0, n_cmp = 0, n_bad = 0, c0;
  typedef struct {
    int inst;
    int cyc;
    logic p, io, to;
    logic [31:0] iv, tv;
    logic [7:0] c, f;
  } exp_t;
  exp_t sbq [$];
  exp_t e;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  sysid_checker #(.READ_LATENCY(0), .AUTO_START(1'b1)) u0 (
    .clock(clock), .reset_n(rst_n[0]), .start(start[0]), .sysid_address(addr[0]), .sysid_read(rd[0]),
    .sysid_readdata(rdata[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]), .id_ok(id_ok[0]),
    .ts_ok(ts_ok[0]), .id_value(id_val[0]), .ts_value(ts_val[0]), .check_count(cc[0]), .fail_count(fc[0]));
  sysid_checker #(.READ_LATENCY(3), .AUTO_START(1'b0)) u1 (
    .clock(clock), .reset_n(rst_n[1]), .start(start[1]), .sysid_address(addr[1]), .sysid_read(rd[1]),
    .sysid_readdata(rdata[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]), .id_ok(id_ok[1]),
    .ts_ok(ts_ok[1]), .id_value(id_val[1]), .ts_value(ts_val[1]), .check_count(cc[1]), .fail_count(fc[1]));
  sysid_checker #(.READ_LATENCY(2), .AUTO_START(1'b0)) u2 (
    .clock(clock), .reset_n(rst_n[2]), .start(start[2]), .sysid_address(addr[2]), .sysid_read(rd[2]),
    .sysid_readdata(rdata[2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]), .id_ok(id_ok[2]),
    .ts_ok(ts_ok[2]), .id_value(id_val[2]), .ts_value(ts_val[2]), .check_count(cc[2]), .fail_count(fc[2]));
  for (genvar g = 0; g < 3; g++) begin : g_slv
    localparam int L = g == 0 ? 0 : g == 1 ? 3 : 2;
    logic [7:0] pv = '0, pa = '0;
    always @(posedge clock) begin
      pv <= {pv[6:0], rd[g]};
      pa <= {pa[6:0], addr[g]};
    end
    if (L == 0) begin : g_l0
      assign rdata[g] = rd[g] ? (addr[g] ? TS : W0[g]) : 32'hDEAD_BEEF;
    end else begin : g_ln
      assign rdata[g] = pv[L-1] ? (pa[L-1] ? TS : W0[g]) : 32'hDEAD_BEEF;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask
  task automatic push(input int inst, input logic p, io, to, input logic [31:0] iv, tv,
                      input logic [7:0] c, f, input int dc);
    exp_t x;
    x.inst = inst; x.cyc = dc; x.p = p; x.io = io; x.to = to;
    x.iv = iv; x.tv = tv; x.c = c; x.f = f;
    sbq.push_back(x);
  endtask
  task automatic tick();
    @(negedge clock);
  endtask
  always @(negedge clock)
    for (int i = 0; i < 3; i++)
      if (done[i] === 1'b1) begin
        if (sbq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: inst %0d at cycle %0d, required no done", i, cyc);
        end else begin
          e = sbq.pop_front();
          chk("done_inst", 32'(i), 32'(e.inst));
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
          chk("pass", 32'(pass[i]), 32'(e.p));
          chk("id_ok", 32'(id_ok[i]), 32'(e.io));
          chk("ts_ok", 32'(ts_ok[i]), 32'(e.to));
          chk("id_value", id_val[i], e.iv);
          chk("ts_value", ts_val[i], e.tv);
          chk("check_count", 32'(cc[i]), 32'(e.c));
          chk("fail_count", 32'(fc[i]), 32'(e.f));
        end
      end
  initial begin
    rst_n = 3'b000;
    start = 3'b000;
    repeat (3) tick();
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 32'(busy[i]), 0);
      chk("rst_read", 32'(rd[i]), 0);
      chk("rst_count", 32'(cc[i]), 0);
      chk("rst_fail", 32'(fc[i]), 0);
    end
    tick();
    rst_n[0] = 1'b1;
    c0 = cyc;
    push(0, 1, 1, 1, 32'd0, TS, 8'd1, 8'd0, c0 + 3);
    tick();
    chk("s1_rd_c1", 32'(rd[0]), 1);
    chk("s1_addr_c1", 32'(addr[0]), 0);
    chk("s1_busy_c1", 32'(busy[0]), 1);
    tick();
    chk("s1_rd_c2", 32'(rd[0]), 1);
    chk("s1_addr_c2", 32'(addr[0]), 1);
    tick();
    chk("s1_rd_c3", 32'(rd[0]), 0);
    chk("s1_busy_c3", 32'(busy[0]), 0);
    repeat (3) tick();
    start[0] = 1'b1;
    c0 = cyc;
    push(0, 1, 1, 1, 32'd0, TS, 8'd2, 8'd0, c0 + 3);
    tick();
    start[0] = 1'b0;
    tick();
    start[0] = 1'b1;
    tick();
    chk("s1_busy_done_cyc", 32'(busy[0]), 0);
    push(0, 1, 1, 1, 32'd0, TS, 8'd3, 8'd0, cyc + 3);
    tick();
    start[0] = 1'b0;
    chk("s1_relaunch_rd", 32'(rd[0]), 1);
    chk("s1_relaunch_addr", 32'(addr[0]), 0);
    chk("s1_pass_cleared", 32'(pass[0]), 0);
    repeat (5) tick();
    rst_n[1] = 1'b1;
    repeat (3) begin
      tick();
      chk("s2_idle_rd", 32'(rd[1]), 0);
    end
    tick();
    start[1] = 1'b1;
    c0 = cyc;
    push(1, 0, 0, 1, 32'd1, TS, 8'd1, 8'd1, c0 + 9);
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 1) start[1] = 1'b0;
      chk("s2_rd", 32'(rd[1]), 32'(k == 1 || k == 5));
      chk("s2_busy", 32'(busy[1]), 32'(k <= 8));
      if (k <= 8) chk("s2_addr", 32'(addr[1]), 32'(k >= 5));
    end
    tick();
    rst_n[2] = 1'b1;
    tick();
    start[2] = 1'b1;
    c0 = cyc;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) start[2] = 1'b0;
      chk("s3_rd", 32'(rd[2]), 32'(k == 1 || k == 4));
      chk("s3_busy", 32'(busy[2]), 1);
    end
    chk("s3_addr_wait_ts", 32'(addr[2]), 1);
    chk("s3_idv_pre", id_val[2], 32'h1234_5678);
    rst_n[2] = 1'b0;
    #1;
    chk("s3_async_busy", 32'(busy[2]), 0);
    chk("s3_async_addr", 32'(addr[2]), 0);
    chk("s3_async_rd", 32'(rd[2]), 0);
    chk("s3_async_idv", id_val[2], 0);
    chk("s3_async_done", 32'(done[2]), 0);
    tick();
    tick();
    rst_n[2] = 1'b1;
    repeat (8) begin
      tick();
      chk("s3_no_auto_rd", 32'(rd[2]), 0);
      chk("s3_no_auto_busy", 32'(busy[2]), 0);
    end
    start[2] = 1'b1;
    c0 = cyc;
    push(2, 0, 0, 1, 32'h1234_5678, TS, 8'd1, 8'd1, c0 + 7);
    tick();
    start[2] = 1'b0;
    chk("s3_start_rd", 32'(rd[2]), 1);
    repeat (8) tick();
    rst_n[1] = 1'b0;
    tick();
    chk("s4_rst_count", 32'(cc[1]), 0);
    chk("s4_rst_fail", 32'(fc[1]), 0);
    rst_n[1] = 1'b1;
    tick();
    for (int k = 1; k <= 256; k++) begin
      start[1] = 1'b1;
      c0 = cyc;
      push(1, 0, 0, 1, 32'd1, TS, 8'(k), 8'(k > 255 ? 255 : k), c0 + 9);
      tick();
      start[1] = 1'b0;
      repeat (8) tick();
    end
    repeat (12) tick();
    chk("s4_final_count", 32'(cc[1]), 0);
    chk("s4_final_fail", 32'(fc[1]), 255);
    chk("s4_final_pass", 32'(pass[1]), 0);
    chk("sb_drained", 32'(sbq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
